// File: rtl/tinyalu.sv
// Small multi-cycle ALU: add/and/xor complete one cycle after acceptance,
// mul takes three; each accepted operation ends with a one-cycle done pulse.
module tinyalu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    MUL3 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  a_q, b_q;
  logic [2:0]  op_q;
  logic        done_d;
  logic [15:0] result_d;
  logic        capture;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = (op == OP_MUL) ? MUL1 : EXEC;
        end
      end
      EXEC: begin
        done_d  = 1'b1;
        state_d = DONE;
        // no_op and reserved opcodes fall through and keep the old result
        case (op_q)
          OP_ADD:  result_d = {8'h00, a_q} + {8'h00, b_q};
          OP_AND:  result_d = {8'h00, a_q & b_q};
          OP_XOR:  result_d = {8'h00, a_q ^ b_q};
          default: result_d = result;
        endcase
      end
      MUL1: state_d = MUL2;
      MUL2: state_d = MUL3;
      MUL3: begin
        done_d   = 1'b1;
        state_d  = DONE;
        result_d = {8'h00, a_q} * {8'h00, b_q};
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset is synchronous and active-high despite the port name.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset_n) begin
      state_q <= IDLE;
      done    <= 1'b0;
      result  <= 16'h0000;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      result  <= result_d;
      if (capture) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
      end
    end
  end

endmodule

// File: tb/tb_tinyalu.sv
// Directed self-checking bench for tinyalu: reset, each op, mul latency,
// back-to-back cadence, abort by reset and result hold on no_op/reserved.
module tb_tinyalu;

  logic        clk;
  logic        reset_n;
  logic [7:0]  A, B;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;

  tinyalu dut (
    .clk    (clk),
    .reset_n(reset_n),
    .A      (A),
    .B      (B),
    .op     (op),
    .start  (start),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b1;
    A       = 8'h12;
    B       = 8'h34;
    op      = 3'b001;

    // Reset held two edges with start high
    step();
    check("rst1_done", {15'd0, done}, 16'h0000);
    check("rst1_result", result, 16'h0000);
    step();
    check("rst2_done", {15'd0, done}, 16'h0000);
    check("rst2_result", result, 16'h0000);

    // Release with start still high: first edge accepts FF+01
    reset_n = 1'b0;
    A = 8'hFF; B = 8'h01; op = 3'b001;
    step();                                   // edge N: accept
    start = 1'b0;
    check("add_n_done", {15'd0, done}, 16'h0000);
    step();                                   // N+1
    check("add_n1_done", {15'd0, done}, 16'h0001);
    check("add_result", result, 16'h0100);
    step();                                   // N+2
    check("add_n2_done", {15'd0, done}, 16'h0000);
    check("add_hold", result, 16'h0100);

    // AND
    A = 8'hF0; B = 8'h3C; op = 3'b010; start = 1'b1;
    step();
    start = 1'b0;
    check("and_n_done", {15'd0, done}, 16'h0000);
    step();
    check("and_n1_done", {15'd0, done}, 16'h0001);
    check("and_result", result, 16'h0030);
    step();
    check("and_n2_done", {15'd0, done}, 16'h0000);

    // XOR
    op = 3'b011; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("xor_n1_done", {15'd0, done}, 16'h0001);
    check("xor_result", result, 16'h00CC);
    step();
    check("xor_n2_done", {15'd0, done}, 16'h0000);

    // MUL FF*FF, operands changed during MUL1 with start high
    A = 8'hFF; B = 8'hFF; op = 3'b100; start = 1'b1;
    step();                                   // N: accept
    A = 8'h00; B = 8'h00;
    check("mul_n_done", {15'd0, done}, 16'h0000);
    step();                                   // N+1
    check("mul_n1_done", {15'd0, done}, 16'h0000);
    check("mul_n1_hold", result, 16'h00CC);
    step();                                   // N+2
    check("mul_n2_done", {15'd0, done}, 16'h0000);
    step();                                   // N+3
    check("mul_n3_done", {15'd0, done}, 16'h0001);
    check("mul_result", result, 16'hFE01);
    step();                                   // N+4: back to IDLE
    check("mul_n4_done", {15'd0, done}, 16'h0000);
    step();                                   // N+5: next accept (0*0)
    start = 1'b0;
    check("mul_n5_done", {15'd0, done}, 16'h0000);
    step();
    step();
    check("mul2_n7_done", {15'd0, done}, 16'h0000);
    step();                                   // N+8
    check("mul2_cadence_done", {15'd0, done}, 16'h0001);
    check("mul2_result", result, 16'h0000);
    step();
    check("mul2_after_done", {15'd0, done}, 16'h0000);

    // Add to 0x0100, then no_op and reserved must hold it
    A = 8'hFF; B = 8'h01; op = 3'b001; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("add2_result", result, 16'h0100);
    step();
    op = 3'b000; A = 8'h55; B = 8'h0F; start = 1'b1;
    step();
    start = 1'b0;
    check("nop_n_done", {15'd0, done}, 16'h0000);
    step();
    check("nop_n1_done", {15'd0, done}, 16'h0001);
    check("nop_hold", result, 16'h0100);
    step();
    check("nop_n2_done", {15'd0, done}, 16'h0000);
    op = 3'b110; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("rsv_n1_done", {15'd0, done}, 16'h0001);
    check("rsv_hold", result, 16'h0100);
    step();
    check("rsv_n2_done", {15'd0, done}, 16'h0000);

    // Reset during MUL2 aborts with no done pulse
    A = 8'h10; B = 8'h10; op = 3'b100; start = 1'b1;
    step();                                   // MUL1
    start = 1'b0;
    step();                                   // MUL2
    reset_n = 1'b1;
    step();                                   // reset edge
    reset_n = 1'b0;
    check("abort_done", {15'd0, done}, 16'h0000);
    check("abort_result", result, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_quiet_done", {15'd0, done}, 16'h0000);
      check("abort_quiet_result", result, 16'h0000);
    end

    // IDLE after abort: a fresh XOR completes one edge after acceptance
    A = 8'hA5; B = 8'h0F; op = 3'b011; start = 1'b1;
    step();
    start = 1'b0;
    check("post_abort_n_done", {15'd0, done}, 16'h0000);
    step();
    check("post_abort_n1_done", {15'd0, done}, 16'h0001);
    check("post_abort_result", result, 16'h00AA);
    step();
    check("post_abort_n2_done", {15'd0, done}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tinyalu.md
TINYALU -- requirements
Module: tinyalu

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, input, 1: sole clock; all state updates on its rising edge.
- reset_n, input, 1: synchronous, active-high reset. The port keeps the codebase name; the _n suffix does not imply low polarity.
- A, input, 8: operand A, unsigned.
- B, input, 8: operand B, unsigned.
- op, input, 3: opcode. 000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101-111 reserved.
- start, input, 1: operation request, sampled on the rising edge.
- done, output, 1: one-cycle completion pulse.
- result, output, 16: registered operation result.

Function
REQ-003 The FSM SHALL have the states IDLE, EXEC, MUL1, MUL2, MUL3 and DONE.
REQ-004 Acceptance: on a rising edge with state IDLE and start=1, the block SHALL capture A, B and op into internal registers.
- The next state SHALL be MUL1 if the captured op is 100; otherwise EXEC.
REQ-005 In any state other than IDLE, start, A, B and op SHALL be ignored.
- Computation SHALL use only the captured operands.
REQ-006 For an operation accepted at edge N, single-cycle ops (op other than 100) SHALL complete at edge N+1 (EXEC to DONE):
- result is updated;
- done is set to 1.
REQ-007 For mul accepted at edge N, the state SHALL step MUL1 (after N), MUL2 (after N+1), MUL3 (after N+2).
- At edge N+3, result SHALL be updated, done set to 1, and the state SHALL move to DONE.
REQ-008 From DONE, the next edge SHALL clear done to 0 and return to IDLE.
- done SHALL therefore be high for exactly one clock cycle per accepted operation.
REQ-009 With start held high continuously, a new operation SHALL be accepted every 3 cycles for single-cycle ops and every 5 cycles for mul.
REQ-010 Each op SHALL produce the following result:
- add: result = {7'b0, A+B}, a 9-bit sum with the carry kept in bit 8.
- and: result = {8'b0, A&B}.
- xor: result = {8'b0, A^B}.
- mul: result = A*B as the full unsigned 16-bit product, with no truncation.
REQ-011 no_op and the reserved opcodes 101-111 SHALL follow the single-cycle timing and pulse done.
- result SHALL hold its previous value.
REQ-012 result SHALL hold its value at all times except the completion edge of an operation.
REQ-013 done SHALL never be asserted without a preceding accepted operation.
- done SHALL never be asserted twice for one operation.

Reset
REQ-014 On a rising edge with reset_n=1, the block SHALL set:
- state to IDLE;
- done to 0;
- result to 16'h0000;
- the captured A, B and op registers to 0.
REQ-015 Reset SHALL take priority over every other action on the same edge, including acceptance and completion.
REQ-016 A reset during EXEC or MUL1-MUL3 SHALL abort the operation with no done pulse.
- result SHALL be 16'h0000 after the reset edge.
REQ-017 While reset_n=1, start SHALL be ignored.
- Operation acceptance SHALL begin on the first edge with reset_n=0.

Verification
REQ-018 Reset: hold reset_n=1 for 2 cycles with start=1 -> result=16'h0000 and done=0 throughout; with start still high, the first accept occurs on the first edge after release.
REQ-019 Add: A=8'hFF, B=8'h01, op=001, start accepted at edge N -> done=1 only between edges N+1 and N+2, result=16'h0100.
REQ-020 Logic ops:
- A=8'hF0, B=8'h3C, op=010 -> result=16'h0030.
- Same operands, op=011 -> result=16'h00CC.
- Each completes with a single done pulse at N+1.
REQ-021 Mul:
- A=8'hFF, B=8'hFF, op=100 accepted at N -> done=0 at N+1 and N+2, done=1 at N+3, result=16'hFE01.
- Changing A and B to 8'h00 during MUL1 with start high does not alter the result.
REQ-022 Reset mid-multiply: assert reset_n=1 for one edge while in MUL2 -> no done pulse, result=16'h0000, state IDLE.
REQ-023 No_op and reserved op: after an add producing 16'h0100, issue op=000, then op=110 -> each gives one done pulse at N+1 and result stays 16'h0100.
